// File: rtl/scancode_decoder.sv
// scancode_decoder: collapses PS/2 set-2 prefix sequences into key events, tracks modifiers/locks, buffers events in a FIFO
module scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_keycode,
  input  logic       i_keycode_valid,
  output logic       o_event_valid,
  input  logic       i_event_ready,
  output logic [7:0] o_event_code,
  output logic       o_event_break,
  output logic       o_event_ext,
  output logic [2:0] o_event_mods,
  output logic [2:0] o_led_status,
  output logic       o_overflow
);
  localparam int CW = FIFO_AW + 1;
  localparam logic [23:0] LOCKS = {8'h58, 8'h77, 8'h7E};
  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic lsh_q, lsh_d, rsh_q, rsh_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic [2:0] led_q, led_d, held_q, held_d;
  logic emit, brk, ext, drop;
  logic [7:0] code;
  logic [2:0] mods_d;
  logic [12:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] fcnt_q;
  logic full, push, pop;
  assign drop = i_keycode inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    emit = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    code = i_keycode;
    if (i_keycode_valid)
      case (state_q)
        S_IDLE:
          if (i_keycode == 8'hE0) state_d = S_E0;
          else if (i_keycode == 8'hF0) state_d = S_F0;
          else if (i_keycode == 8'hE1) begin
            state_d = S_PAUSE;
            cnt_d = 3'd0;
          end else emit = !drop;
        S_E0:
          if (i_keycode == 8'hF0) state_d = S_E0F0;
          else if (i_keycode != 8'hE0) begin
            emit = 1'b1;
            ext = 1'b1;
            state_d = S_IDLE;
          end
        S_F0:
          if (i_keycode == 8'hE0) state_d = S_E0;
          else if (i_keycode != 8'hF0) begin
            emit = 1'b1;
            brk = 1'b1;
            state_d = S_IDLE;
          end
        S_E0F0:
          if (i_keycode == 8'hE0) state_d = S_E0;
          else if (i_keycode != 8'hF0) begin
            emit = 1'b1;
            brk = 1'b1;
            ext = 1'b1;
            state_d = S_IDLE;
          end
        S_PAUSE: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd6) begin
            emit = 1'b1;
            code = 8'hE1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
  end
  // E0-prefixed 12/59 is the fake shift and must not touch shift state
  always_comb begin
    lsh_d = (emit && !ext && code == 8'h12) ? !brk : lsh_q;
    rsh_d = (emit && !ext && code == 8'h59) ? !brk : rsh_q;
    ctrl_d = (emit && code == 8'h14) ? !brk : ctrl_q;
    alt_d = (emit && code == 8'h11) ? !brk : alt_q;
    mods_d = {alt_d, ctrl_d, lsh_d | rsh_d};
    held_d = held_q;
    led_d = led_q;
    for (int i = 0; i < 3; i++)
      if (emit && !ext && code == LOCKS[i*8 +: 8]) begin
        held_d[i] = !brk;
        led_d[i] = led_q[i] ^ (!brk && !held_q[i]);
      end
  end
  assign o_event_valid = fcnt_q != '0;
  assign full = fcnt_q == CW'(FIFO_DEPTH);
  assign pop = o_event_valid && i_event_ready;
  assign push = emit && (!full || pop);
  assign {o_event_break, o_event_ext, o_event_mods, o_event_code} = o_event_valid ? mem[rptr_q] : '0;
  assign o_led_status = led_q;
  always_ff @(posedge i_clk)
    if (push) mem[wptr_q] <= {brk, ext, mods_d, code};
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      {lsh_q, rsh_q, ctrl_q, alt_q} <= '0;
      led_q <= '0;
      held_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      o_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      {lsh_q, rsh_q, ctrl_q, alt_q} <= {lsh_d, rsh_d, ctrl_d, alt_d};
      led_q <= led_d;
      held_q <= held_d;
      wptr_q <= push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
      o_overflow <= o_overflow | (emit && full && !pop);
    end
endmodule
